// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: forwards ALU results to WB and runs one
// data-memory access per instruction with a req/ack handshake. Optional access timeout: MEM_TIMEOUT_EN.
module mem_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  MEM_Reg_WriteAddr,
    input  logic        MEM_Reg_WriteEn,
    input  logic [31:0] MEM_AluResult,
    input  logic        MEM_Mem2R,
    input  logic [9:0]  MEM_DMem_WriteAddr,
    input  logic        MEM_DMem_WriteEn,
    input  logic        MEM_DMem_ReadEn,
    input  logic [31:0] MEM_DMem_WriteData,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [9:0]  dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  WB_Reg_WriteAddr,
    output logic        WB_Reg_WriteEn,
    output logic [31:0] WB_Reg_WriteData,
    output logic        mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stateT;

    stateT       stateReg, stateNext;
    logic        accessPending;
    logic        latchEn;
    logic        timeout;

    // Access context captured when leaving IDLE; held stable for the whole access
    logic [9:0]  addrReg;
    logic [31:0] wdataReg;
    logic        weReg;
    logic        mem2RReg;
    logic [4:0]  regAddrReg;
    logic        regEnReg;
    logic [31:0] aluReg;

    logic [4:0]  wbAddrNext;
    logic        wbEnNext;
    logic [31:0] wbDataNext;

    assign accessPending = MEM_DMem_ReadEn | MEM_DMem_WriteEn;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] timeoutCnt;
    logic       errReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeoutCnt <= 4'd0;
        end else if (stateReg == IDLE) begin
            timeoutCnt <= 4'd0;
        end else if (!dmem_ack) begin
            timeoutCnt <= timeoutCnt + 4'd1;
        end
    end

    // Fires in the 16th un-acked ACCESS cycle; an ack in that cycle wins
    assign timeout = (stateReg == ACCESS) && !dmem_ack && (timeoutCnt == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errReg <= 1'b0;
        end else if (timeout) begin
            errReg <= 1'b1;
        end
    end

    assign mem_err = errReg;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        mem_stall  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 10'd0;
        dmem_wdata = 32'd0;
        latchEn    = 1'b0;
        wbAddrNext = 5'd0;
        wbEnNext   = 1'b0;
        wbDataNext = 32'd0;
        case (stateReg)
            IDLE: begin
                if (accessPending) begin
                    mem_stall = 1'b1;
                    latchEn   = 1'b1;
                    stateNext = ACCESS;
                end else begin
                    wbAddrNext = MEM_Reg_WriteAddr;
                    wbEnNext   = MEM_Reg_WriteEn;
                    wbDataNext = MEM_AluResult;
                end
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = weReg;
                dmem_addr  = addrReg;
                dmem_wdata = wdataReg;
                mem_stall  = !(dmem_ack || timeout);
                if (dmem_ack) begin
                    stateNext  = IDLE;
                    wbAddrNext = regAddrReg;
                    wbEnNext   = regEnReg;
                    wbDataNext = mem2RReg ? dmem_rdata : aluReg;
                end else if (timeout) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Stall must never hold the pipeline while reset is asserted
        if (!rst) begin
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrReg          <= 10'd0;
            wdataReg         <= 32'd0;
            weReg            <= 1'b0;
            mem2RReg         <= 1'b0;
            regAddrReg       <= 5'd0;
            regEnReg         <= 1'b0;
            aluReg           <= 32'd0;
            WB_Reg_WriteAddr <= 5'd0;
            WB_Reg_WriteEn   <= 1'b0;
            WB_Reg_WriteData <= 32'd0;
        end else begin
            WB_Reg_WriteAddr <= wbAddrNext;
            WB_Reg_WriteEn   <= wbEnNext;
            WB_Reg_WriteData <= wbDataNext;
            if (latchEn) begin
                addrReg    <= MEM_DMem_WriteAddr;
                wdataReg   <= MEM_DMem_WriteData;
                weReg      <= MEM_DMem_WriteEn;
                mem2RReg   <= MEM_Mem2R;
                regAddrReg <= MEM_Reg_WriteAddr;
                regEnReg   <= MEM_Reg_WriteEn;
                aluReg     <= MEM_AluResult;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: acts as EX/MEM register and data memory,
// queues the expected WB result per instruction and compares it on completion.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  MEM_Reg_WriteAddr;
    logic        MEM_Reg_WriteEn;
    logic [31:0] MEM_AluResult;
    logic        MEM_Mem2R;
    logic [9:0]  MEM_DMem_WriteAddr;
    logic        MEM_DMem_WriteEn;
    logic        MEM_DMem_ReadEn;
    logic [31:0] MEM_DMem_WriteData;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [4:0]  WB_Reg_WriteAddr;
    logic        WB_Reg_WriteEn;
    logic [31:0] WB_Reg_WriteData;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .MEM_Reg_WriteAddr  (MEM_Reg_WriteAddr),
        .MEM_Reg_WriteEn    (MEM_Reg_WriteEn),
        .MEM_AluResult      (MEM_AluResult),
        .MEM_Mem2R          (MEM_Mem2R),
        .MEM_DMem_WriteAddr (MEM_DMem_WriteAddr),
        .MEM_DMem_WriteEn   (MEM_DMem_WriteEn),
        .MEM_DMem_ReadEn    (MEM_DMem_ReadEn),
        .MEM_DMem_WriteData (MEM_DMem_WriteData),
        .mem_stall          (mem_stall),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .WB_Reg_WriteAddr   (WB_Reg_WriteAddr),
        .WB_Reg_WriteEn     (WB_Reg_WriteEn),
        .WB_Reg_WriteData   (WB_Reg_WriteData),
        .mem_err            (mem_err)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic        en;
        logic [31:0] data;
    } wbT;

    wbT expQ[$];
    int vecCount = 0;
    int errCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        checkVal({tag, "_req"},    32'(dmem_req), 32'd0);
        checkVal({tag, "_we"},     32'(dmem_we), 32'd0);
        checkVal({tag, "_addr"},   32'(dmem_addr), 32'd0);
        checkVal({tag, "_wdata"},  dmem_wdata, 32'd0);
        checkVal({tag, "_stall"},  32'(mem_stall), 32'd0);
        checkVal({tag, "_wbaddr"}, 32'(WB_Reg_WriteAddr), 32'd0);
        checkVal({tag, "_wben"},   32'(WB_Reg_WriteEn), 32'd0);
        checkVal({tag, "_wbdata"}, WB_Reg_WriteData, 32'd0);
        checkVal({tag, "_err"},    32'(mem_err), 32'd0);
    endtask

    task automatic driveInstr(input logic [4:0] ra, input logic ren, input logic [31:0] alu,
                              input logic m2r, input logic [9:0] da, input logic dwe,
                              input logic dre, input logic [31:0] wd);
        MEM_Reg_WriteAddr  = ra;
        MEM_Reg_WriteEn    = ren;
        MEM_AluResult      = alu;
        MEM_Mem2R          = m2r;
        MEM_DMem_WriteAddr = da;
        MEM_DMem_WriteEn   = dwe;
        MEM_DMem_ReadEn    = dre;
        MEM_DMem_WriteData = wd;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after WB is written.
    task automatic runInstr(input string name, input logic [4:0] ra, input logic ren,
                            input logic [31:0] alu, input logic m2r, input logic [9:0] da,
                            input logic dwe, input logic dre, input logic [31:0] wd,
                            input int waitCyc, input logic [31:0] rd, input logic ackIdle);
        logic pend;
        wbT   e;
        wbT   got;
        int   stallCnt;
        int   reqCnt;
        pend = dwe | dre;
        driveInstr(ra, ren, alu, m2r, da, dwe, dre, wd);
        e.addr = ra;
        e.en   = ren;
        e.data = (pend && m2r) ? rd : alu;
        expQ.push_back(e);
        stallCnt   = 0;
        reqCnt     = 0;
        dmem_ack   = ackIdle;
        dmem_rdata = $urandom;
        #1;
        checkVal("idle_req", 32'(dmem_req), 32'd0);
        checkVal("idle_stall", 32'(mem_stall), 32'(pend));
        if (mem_stall) stallCnt++;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        if (pend) begin
            checkVal("bubble_en", 32'(WB_Reg_WriteEn), 32'd0);
            checkVal("bubble_addr", 32'(WB_Reg_WriteAddr), 32'd0);
            for (int w = 0; w <= waitCyc; w++) begin
                dmem_ack   = (w == waitCyc);
                dmem_rdata = (w == waitCyc) ? rd : $urandom;
                #1;
                if (dmem_req) reqCnt++;
                if (mem_stall) stallCnt++;
                checkVal("acc_req", 32'(dmem_req), 32'd1);
                checkVal("acc_we", 32'(dmem_we), 32'(dwe));
                checkVal("acc_addr", 32'(dmem_addr), 32'(da));
                checkVal("acc_wdata", dmem_wdata, wd);
                checkVal("acc_stall", 32'(mem_stall), 32'(w != waitCyc));
                @(posedge clk);
                #1;
                dmem_ack = 1'b0;
                if (w < waitCyc) begin
                    checkVal("acc_bubble_en", 32'(WB_Reg_WriteEn), 32'd0);
                    checkVal("acc_bubble_addr", 32'(WB_Reg_WriteAddr), 32'd0);
                end
            end
            checkVal("stall_cycles", 32'(stallCnt), 32'(1 + waitCyc));
            checkVal("req_cycles", 32'(reqCnt), 32'(1 + waitCyc));
        end
        got = {WB_Reg_WriteAddr, WB_Reg_WriteEn, WB_Reg_WriteData};
        e   = expQ.pop_front();
        checkVal("wb_addr", 32'(got.addr), 32'(e.addr));
        checkVal("wb_en", 32'(got.en), 32'(e.en));
        checkVal("wb_data", got.data, e.data);
        $display("txn %-10s reg=%0d en=%0b data=0x%08h wait=%0d", name, got.addr, got.en,
                 got.data, waitCyc);
    endtask

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        driveInstr(5'd3, 1'b1, 32'h1111_2222, 1'b1, 10'h55, 1'b0, 1'b1, 32'h0);
        #1;
        checkOutputsZero("reset");
        @(posedge clk);
        #1;
        checkOutputsZero("reset_hold");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Pending read was presented at reset release: it is now in ACCESS; flush it with an ack
        dmem_ack = 1'b1;
        #1;
        checkVal("post_reset_req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;

        runInstr("alu", 5'd5, 1'b1, 32'h0000_1234, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1);
        runInstr("load", 5'd8, 1'b1, 32'h0BAD_0BAD, 1'b1, 10'h010, 1'b0, 1'b1, 32'h0, 3,
                 32'hDEAD_BEEF, 1'b0);
        runInstr("store", 5'd0, 1'b0, 32'h0000_03FF, 1'b0, 10'h3FF, 1'b1, 1'b0, 32'hA5A5_A5A5,
                 0, 32'h1357_9BDF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runInstr("alu_rand", 5'($urandom_range(1, 31)), 1'($urandom), $urandom, 1'b0,
                     10'($urandom), 1'b0, 1'b0, $urandom, 0, 32'h0, 1'($urandom));
        end
        runInstr("rd_wr", 5'd12, 1'b1, 32'hCAFE_0001, 1'b0, 10'h2A0, 1'b1, 1'b1, 32'h0F0F_0F0F,
                 1, 32'h7777_7777, 1'b0);
        for (int i = 0; i < 3; i++) begin
            runInstr("b2b_load", 5'(i + 20), 1'b1, $urandom, 1'b1, 10'($urandom), 1'b0, 1'b1,
                     $urandom, i, $urandom, 1'b0);
        end
        runInstr("ld_alu", 5'd9, 1'b1, 32'h4242_4242, 1'b0, 10'h101, 1'b0, 1'b1, 32'h0, 2,
                 32'h9999_9999, 1'b0);

        // Reset in the middle of an un-acked access
        driveInstr(5'd7, 1'b1, 32'h0, 1'b1, 10'h1C3, 1'b0, 1'b1, 32'hFFFF_0000);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkVal("mid_req_before", 32'(dmem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutputsZero("mid_reset");
        driveInstr(5'd0, 1'b0, 32'h0, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("after_reset_req", 32'(dmem_req), 32'd0);
        $display("txn %-10s access aborted by reset", "rst_mid");
        runInstr("alu_post", 5'd17, 1'b1, 32'h0BEE_F00D, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0, 0,
                 32'h0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        driveInstr(5'd4, 1'b1, 32'h0, 1'b1, 10'h0AA, 1'b0, 1'b1, 32'h0);
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 16; c++) begin
            #1;
            checkVal("to_req", 32'(dmem_req), 32'd1);
            checkVal("to_stall", 32'(mem_stall), 32'(c < 16));
            checkVal("to_err_low", 32'(mem_err), 32'd0);
            @(posedge clk);
            #1;
        end
        checkVal("to_req_drop", 32'(dmem_req), 32'd0);
        checkVal("to_err", 32'(mem_err), 32'd1);
        checkVal("to_wb_en", 32'(WB_Reg_WriteEn), 32'd0);
        $display("txn %-10s load timed out", "timeout");
        runInstr("alu_to", 5'd6, 1'b1, 32'h600D_600D, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0, 0,
                 32'h0, 1'b0);
        checkVal("err_sticky", 32'(mem_err), 32'd1);
`else
        runInstr("slow_load", 5'd11, 1'b1, 32'h0, 1'b1, 10'h3C0, 1'b0, 1'b1, 32'h0, 20,
                 32'h5151_A2A2, 1'b0);
        checkVal("err_tied", 32'(mem_err), 32'd0);
`endif

        checkVal("queue_empty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
